intersect_sched: RTL and testbench
==================================

INTERSECT_SCHED -- requirements
Module: intersect_sched

Interface
REQ-001 Parameter N, default 8: coordinate width, matching the intersection datapath.
REQ-002 Parameter K, default 3: anchors per job, legal range 2..8.
REQ-003 Parameter SETTLE, default 4: cycles allowed for the combinational intersection path to settle, legal range 1..15.
REQ-004 clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 in_valid  in  1  anchor word valid.
REQ-007 in_ready  out  1  anchor word accepted.
REQ-008 in_x, in_y  in  N each  signed anchor coordinates.
REQ-009 in_r  in  N+1  signed anchor range.
REQ-010 ix_xB, ix_yB, ix_xC, ix_yC  out  N each  registered operands to the intersection datapath.
REQ-011 ix_rB, ix_rC  out  N+1 each  registered ranges to the datapath.
REQ-012 ix_x1E, ix_y1E, ix_x2E, ix_y2E  in  N each  datapath results.
REQ-013 out_valid  out  1  result available.
REQ-014 out_ready  in  1  consumer accepts the result.
REQ-015 out_x1, out_y1, out_x2, out_y2  out  N each  captured results.
REQ-016 out_i, out_j  out  3 each  anchor indices of the pair, with out_i < out_j.
REQ-017 out_degen  out  1  set when the pair has equal x, which makes the datapath divide by zero.
REQ-018 out_last  out  1  set on the final pair of the job.
REQ-019 busy  out  1  job in progress.

Function
REQ-020 States: LOAD, SETTLE, PRESENT, DONE.
REQ-021 LOAD: in_ready=1; each in_valid&&in_ready writes anchor slot cnt and increments cnt; on the K-th accept, go to SETTLE with pair (0,1) driven on the ix_* outputs.
REQ-022 ix_* outputs shall be registers that change only on entry to SETTLE; they hold stable through SETTLE and PRESENT.
REQ-023 SETTLE: a wait counter counts SETTLE cycles after the ix_* update; then the module captures ix_x1E..ix_y2E into the out_* registers and goes to PRESENT.
REQ-024 PRESENT: out_valid=1 and out_* are held stable until out_valid&&out_ready.
REQ-025 On that handshake, if the pair is not last: advance to the next pair and go to SETTLE.
REQ-026 On that handshake, if the pair is last: go to DONE.
REQ-027 Pair order is lexicographic: (0,1),(0,2)..(0,K-1),(1,2)..(K-2,K-1); total K(K-1)/2 pairs.
REQ-028 out_degen = (x[i]==x[j]), captured with the results; results are still presented and out_degen is the only indication.
REQ-029 out_last=1 only when the pair is (K-2,K-1).
REQ-030 DONE lasts one cycle with busy=0 and then returns to LOAD with cnt=0.
REQ-031 busy=1 in SETTLE and PRESENT; busy=0 in LOAD and DONE.
REQ-032 in_ready=0 outside LOAD; in_valid outside LOAD is ignored.
REQ-033 Latency from the K-th accept to out_valid shall be exactly SETTLE+1 cycles, and from an out handshake to the next out_valid also SETTLE+1 cycles.
REQ-034 out_ready held high continuously gives one result per SETTLE+2 cycles.
REQ-035 out_ready asserted while out_valid=0 has no effect.
REQ-036 Anchor storage is not modified during SETTLE or PRESENT.

Reset
REQ-037 rst=1 shall immediately set: state LOAD, cnt=0, pair (0,1), wait counter 0.
REQ-038 rst=1 shall immediately clear to 0: out_valid, busy, out_last, out_degen, all out_* data, all ix_* outputs.
REQ-039 in_ready=1 from the first cycle after rst deasserts.
REQ-040 rst asserted mid-job abandons the job; no partial result is held or presented afterwards.

Verification
REQ-041 N=8, K=3, SETTLE=4; anchors (0,0,r5),(6,0,r5),(3,8,r5); datapath model computes from ix_* -> three results in order (0,1),(0,2),(1,2); the first out_valid arrives 5 cycles after the third accept; out_last=1 only on (1,2); out_degen=0 throughout.
REQ-042 Anchors (2,0),(2,5),(7,1) -> pair (0,1) has out_degen=1; pairs (0,2) and (1,2) have out_degen=0.
REQ-043 out_ready held low for 20 cycles in PRESENT -> out_* and out_valid stay constant; a single handshake then advances to exactly the next pair.
REQ-044 in_valid asserted continuously during a job -> in_ready stays 0 and the stored anchors are unchanged; in_ready=1 again the cycle after DONE.
REQ-045 rst pulsed during SETTLE of pair (0,2) -> outputs zero immediately; a new 3-anchor job completes correctly with no stale output.
REQ-046 K=2, out_ready always high -> a single result with out_last=1, followed by DONE and return to LOAD.

Source files
------------

// File: rtl/intersect_sched.sv
// intersect_sched
//   Sequences anchor pairs through an external combinational intersection
//   datapath. A job is K anchors, loaded one word per handshake. For each
//   anchor pair (i<j), in lexicographic order, the module:
//     1. drives the pair on the registered ix_* operands,
//     2. waits a fixed number of cycles for the datapath to settle,
//     3. captures the results, and
//     4. presents them on out_* until the consumer accepts them.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   in_valid/in_ready        anchor load handshake (ready only while loading)
//   in_x, in_y, in_r         anchor coordinates (N) and range (N+1)
//   ix_xB..ix_rC             registered operands to the datapath (pair i=B, j=C)
//   ix_x1E..ix_y2E           datapath results
//   out_valid/out_ready      result handshake
//   out_x1..out_y2           captured results
//   out_i, out_j             anchor indices of the presented pair
//   out_degen                pair has equal x (the datapath divides by zero)
//   out_last                 final pair of the job
//   busy                     job in progress (settling or presenting)
module intersect_sched #(
   parameter int N      = 8,
   parameter int K      = 3,
   parameter int SETTLE = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] in_x,
   input  logic [N-1:0] in_y,
   input  logic [N:0]   in_r,
   output logic [N-1:0] ix_xB,
   output logic [N-1:0] ix_yB,
   output logic [N-1:0] ix_xC,
   output logic [N-1:0] ix_yC,
   output logic [N:0]   ix_rB,
   output logic [N:0]   ix_rC,
   input  logic [N-1:0] ix_x1E,
   input  logic [N-1:0] ix_y1E,
   input  logic [N-1:0] ix_x2E,
   input  logic [N-1:0] ix_y2E,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] out_x1,
   output logic [N-1:0] out_y1,
   output logic [N-1:0] out_x2,
   output logic [N-1:0] out_y2,
   output logic [2:0]   out_i,
   output logic [2:0]   out_j,
   output logic         out_degen,
   output logic         out_last,
   output logic         busy
);

   typedef enum logic [1:0] {ST_LOAD, ST_SETTLE, ST_PRESENT, ST_DONE} state_t;

   localparam logic [2:0] KM1  = 3'(K - 1);
   localparam logic [2:0] KM2  = 3'(K - 2);
   localparam logic [3:0] WMAX = 4'(SETTLE);

   state_t state, nstate;

   logic [2:0] cnt;       // next anchor slot to load
   logic [2:0] pi, pj;    // current pair
   logic [2:0] ni, nj;    // pair that follows (pi,pj)
   logic [3:0] wcnt;      // settle wait counter

   // Storage is sized for the full 3-bit index space so pair indices never
   // select outside the array; only slots 0..K-1 are ever written.
   logic [7:0][N-1:0] ax, ay, wx, wy;
   logic [7:0][N:0]   ar, wr;

   logic accept, load_done, settle_done, last_pair, out_hs;

   assign accept      = (state == ST_LOAD) && in_valid;
   assign load_done   = accept && (cnt == KM1);
   assign settle_done = (state == ST_SETTLE) && (wcnt == WMAX);
   assign last_pair   = (pi == KM2) && (pj == KM1);
   assign out_hs      = (state == ST_PRESENT) && out_ready;

   // Lexicographic successor: bump j, or wrap to (i+1, i+2).
   always_comb begin
      ni = pi;
      nj = pj + 3'd1;
      if (pj == KM1) begin
         ni = pi + 3'd1;
         nj = pi + 3'd2;
      end
   end

   // Anchor view including the word being accepted this cycle, so pair (0,1)
   // can be driven on the same edge as the final accept (needed when K=2).
   always_comb begin
      wx = ax;
      wy = ay;
      wr = ar;
      if (accept) begin
         wx[cnt] = in_x;
         wy[cnt] = in_y;
         wr[cnt] = in_r;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_LOAD;
      else     state <= nstate;
   end

   always_comb begin
      nstate    = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      case (state)
         ST_LOAD: begin
            in_ready = 1'b1;
            if (load_done) nstate = ST_SETTLE;
         end
         ST_SETTLE: begin
            busy = 1'b1;
            if (settle_done) nstate = ST_PRESENT;
         end
         ST_PRESENT: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            if (out_ready) nstate = last_pair ? ST_DONE : ST_SETTLE;
         end
         ST_DONE: nstate = ST_LOAD;
         default: nstate = ST_LOAD;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ax        <= '0;
         ay        <= '0;
         ar        <= '0;
         cnt       <= 3'd0;
         pi        <= 3'd0;
         pj        <= 3'd1;
         wcnt      <= 4'd0;
         ix_xB     <= '0;
         ix_yB     <= '0;
         ix_xC     <= '0;
         ix_yC     <= '0;
         ix_rB     <= '0;
         ix_rC     <= '0;
         out_x1    <= '0;
         out_y1    <= '0;
         out_x2    <= '0;
         out_y2    <= '0;
         out_i     <= 3'd0;
         out_j     <= 3'd0;
         out_degen <= 1'b0;
         out_last  <= 1'b0;
      end else begin
         if (accept) begin
            ax[cnt] <= in_x;
            ay[cnt] <= in_y;
            ar[cnt] <= in_r;
            cnt     <= load_done ? 3'd0 : cnt + 3'd1;
         end

         if (load_done) begin
            pi    <= 3'd0;
            pj    <= 3'd1;
            wcnt  <= 4'd0;
            ix_xB <= wx[0];
            ix_yB <= wy[0];
            ix_rB <= wr[0];
            ix_xC <= wx[1];
            ix_yC <= wy[1];
            ix_rC <= wr[1];
         end

         // Wait counter runs from 0 on entry; capture once it has reached
         // SETTLE, giving SETTLE+1 cycles from the ix_* update to out_valid.
         if (state == ST_SETTLE) begin
            if (settle_done) begin
               wcnt      <= 4'd0;
               out_x1    <= ix_x1E;
               out_y1    <= ix_y1E;
               out_x2    <= ix_x2E;
               out_y2    <= ix_y2E;
               out_i     <= pi;
               out_j     <= pj;
               out_degen <= (ix_xB == ix_xC);
               out_last  <= last_pair;
            end else begin
               wcnt <= wcnt + 4'd1;
            end
         end

         if (out_hs && !last_pair) begin
            pi    <= ni;
            pj    <= nj;
            wcnt  <= 4'd0;
            ix_xB <= ax[ni];
            ix_yB <= ay[ni];
            ix_rB <= ar[ni];
            ix_xC <= ax[nj];
            ix_yC <= ay[nj];
            ix_rC <= ar[nj];
         end

         if (state == ST_DONE) begin
            cnt <= 3'd0;
            pi  <= 3'd0;
            pj  <= 3'd1;
         end
      end
   end

endmodule

// File: tb/tb_intersect_sched.sv
// tb_intersect_sched
//   Table-driven jobs, hand-written corner sequences (held in_valid, reset
//   mid-job, K=2) and random jobs, all checked against a pair-list model.
//   The datapath stand-in only returns correct results once its operands
//   have been stable for SETTLE cycles, otherwise a garbage pattern.
module tb_intersect_sched;

   localparam int N      = 8;
   localparam int SETTLE = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int tests  = 0;
   int failed = 0;

   // K=3 instance
   logic         in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
   logic [N-1:0] in_x = '0, in_y = '0;
   logic [N:0]   in_r = '0;
   logic [N-1:0] ix_xB, ix_yB, ix_xC, ix_yC, ix_x1E, ix_y1E, ix_x2E, ix_y2E;
   logic [N:0]   ix_rB, ix_rC;
   logic [N-1:0] out_x1, out_y1, out_x2, out_y2;
   logic [2:0]   out_i, out_j;
   logic         out_degen, out_last, busy;

   // K=2 instance
   logic         in_valid2 = 1'b0, in_ready2, out_valid2, out_ready2 = 1'b0;
   logic [N-1:0] in_x2 = '0, in_y2 = '0;
   logic [N:0]   in_r2 = '0;
   logic [N-1:0] ix2_xB, ix2_yB, ix2_xC, ix2_yC, ix2_x1E, ix2_y1E, ix2_x2E, ix2_y2E;
   logic [N:0]   ix2_rB, ix2_rC;
   logic [N-1:0] out2_x1, out2_y1, out2_x2, out2_y2;
   logic [2:0]   out2_i, out2_j;
   logic         out2_degen, out2_last, busy2;

   intersect_sched #(.N(N), .K(3), .SETTLE(SETTLE)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_x(in_x), .in_y(in_y), .in_r(in_r),
      .ix_xB(ix_xB), .ix_yB(ix_yB), .ix_xC(ix_xC), .ix_yC(ix_yC),
      .ix_rB(ix_rB), .ix_rC(ix_rC),
      .ix_x1E(ix_x1E), .ix_y1E(ix_y1E), .ix_x2E(ix_x2E), .ix_y2E(ix_y2E),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_x1(out_x1), .out_y1(out_y1), .out_x2(out_x2), .out_y2(out_y2),
      .out_i(out_i), .out_j(out_j), .out_degen(out_degen),
      .out_last(out_last), .busy(busy));

   intersect_sched #(.N(N), .K(2), .SETTLE(SETTLE)) dut2 (
      .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
      .in_x(in_x2), .in_y(in_y2), .in_r(in_r2),
      .ix_xB(ix2_xB), .ix_yB(ix2_yB), .ix_xC(ix2_xC), .ix_yC(ix2_yC),
      .ix_rB(ix2_rB), .ix_rC(ix2_rC),
      .ix_x1E(ix2_x1E), .ix_y1E(ix2_y1E), .ix_x2E(ix2_x2E), .ix_y2E(ix2_y2E),
      .out_valid(out_valid2), .out_ready(out_ready2),
      .out_x1(out2_x1), .out_y1(out2_y1), .out_x2(out2_x2), .out_y2(out2_y2),
      .out_i(out2_i), .out_j(out2_j), .out_degen(out2_degen),
      .out_last(out2_last), .busy(busy2));

   // Stand-in intersection function: any deterministic mix of the operands.
   function automatic logic [31:0] dp_f(input logic [7:0] xb, yb, xc, yc,
                                        input logic [8:0] rb, rc);
      logic [7:0] a, b, c, d;
      a = xb + xc;
      b = yb + yc;
      c = xb - xc + rb[7:0];
      d = (yc - yb) ^ rc[7:0];
      return {a, b, c, d};
   endfunction

   // Operand age, counted on falling edges since the ix_* last changed.
   logic [49:0] ix_prev = '0;
   int age = 0;
   always @(negedge clk) begin
      if ({ix_xB, ix_yB, ix_xC, ix_yC, ix_rB, ix_rC} != ix_prev) age = 0;
      else if (age < 1000) age = age + 1;
      ix_prev = {ix_xB, ix_yB, ix_xC, ix_yC, ix_rB, ix_rC};
   end

   assign {ix_x1E, ix_y1E, ix_x2E, ix_y2E} = (age >= SETTLE) ?
      dp_f(ix_xB, ix_yB, ix_xC, ix_yC, ix_rB, ix_rC) : 32'hA5A5_5A5A;
   assign {ix2_x1E, ix2_y1E, ix2_x2E, ix2_y2E} =
      dp_f(ix2_xB, ix2_yB, ix2_xC, ix2_yC, ix2_rB, ix2_rC);

   typedef struct packed {
      logic [2:0][7:0] xs;
      logic [2:0][7:0] ys;
      logic [2:0][8:0] rs;
      logic [2:0]      dg;     // expected degen per pair, bit p = p-th pair
      logic [7:0]      stall;  // cycles out_ready is held low per result
   } vec_t;

   typedef struct packed {
      logic [2:0]  i, j;
      logic [31:0] res;
      logic        dg, last;
   } exp_t;

   function automatic vec_t mk(input int x0, y0, r0, x1, y1, r1, x2, y2, r2,
                               input logic [2:0] dg, input int st);
      vec_t v;
      v.xs[0] = 8'(x0); v.ys[0] = 8'(y0); v.rs[0] = 9'(r0);
      v.xs[1] = 8'(x1); v.ys[1] = 8'(y1); v.rs[1] = 9'(r1);
      v.xs[2] = 8'(x2); v.ys[2] = 8'(y2); v.rs[2] = 9'(r2);
      v.dg    = dg;
      v.stall = 8'(st);
      return v;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Loads three anchors; returns at the falling edge after the final accept.
   task automatic load3(input vec_t v);
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         in_valid = 1'b1;
         in_x = v.xs[2'(k)];
         in_y = v.ys[2'(k)];
         in_r = v.rs[2'(k)];
         chk("in_ready_load", 64'(in_ready), 64'd1);
         @(negedge clk);
      end
   endtask

   task automatic run_job(input vec_t v, input bit use_dg, input bit hold_valid);
      exp_t q[$];
      exp_t e;
      int lat;
      logic [39:0] snap;
      for (int i = 0; i < 3; i++)
         for (int j = i + 1; j < 3; j++) begin
            e.i    = 3'(i);
            e.j    = 3'(j);
            e.res  = dp_f(v.xs[2'(i)], v.ys[2'(i)], v.xs[2'(j)], v.ys[2'(j)],
                          v.rs[2'(i)], v.rs[2'(j)]);
            e.dg   = (v.xs[2'(i)] == v.xs[2'(j)]);
            e.last = 1'b0;
            q.push_back(e);
         end
      e = q[q.size()-1];
      e.last = 1'b1;
      q[q.size()-1] = e;

      out_ready = 1'b0;
      load3(v);
      if (!hold_valid) in_valid = 1'b0;
      out_ready = (v.stall == 0);
      for (int p = 0; p < q.size(); p++) begin
         e = q[p];
         lat = 1;
         while (!out_valid && lat < 100) begin
            if (hold_valid) begin
               chk("in_ready_busy", 64'(in_ready), 64'd0);
               in_x = 8'($urandom);
               in_y = 8'($urandom);
               in_r = 9'($urandom);
            end
            @(negedge clk);
            lat++;
         end
         chk("latency", 64'(lat - 1), 64'(SETTLE + 1));
         chk("busy_present", 64'(busy), 64'd1);
         chk("pair", 64'({out_i, out_j}), 64'({e.i, e.j}));
         chk("result", 64'({out_x1, out_y1, out_x2, out_y2}), 64'(e.res));
         chk("degen", 64'(out_degen), 64'(use_dg ? v.dg[2'(p)] : e.dg));
         chk("last", 64'(out_last), 64'(e.last));
         if (v.stall != 0) begin
            snap = {out_x1, out_y1, out_x2, out_y2, out_i, out_j, out_degen, out_last};
            repeat (int'(v.stall)) @(negedge clk);
            chk("hold", 64'({out_valid, out_x1, out_y1, out_x2, out_y2, out_i, out_j,
                             out_degen, out_last}), 64'({1'b1, snap}));
            out_ready = 1'b1;
         end
         @(negedge clk);
         out_ready = (v.stall == 0);
      end
      chk("done_busy", 64'({busy, in_ready, out_valid}), 64'd0);
      in_valid = 1'b0;
      out_ready = 1'b0;
      @(negedge clk);
      chk("reload_ready", 64'({in_ready, busy}), 64'b10);
   endtask

   vec_t tbl[4];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      vec_t v;
      int lat;
      logic [31:0] r2;

      tbl[0] = mk( 0, 0, 5,   6,  0, 5,   3, 8, 5, 3'b000, 0);
      tbl[1] = mk( 2, 0, 3,   2,  5, 4,   7, 1, 5, 3'b001, 0);
      tbl[2] = mk(-3, 4, 10,  5, -2, 7,  -3, 9, 2, 3'b010, 20);
      tbl[3] = mk( 1, 1, 1,   1,  1, 1,   1, 1, 1, 3'b111, 1);

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_ctl", 64'({out_valid, busy, out_last, out_degen}), 64'd0);
      chk("rst_out", 64'({out_x1, out_y1, out_x2, out_y2, out_i, out_j}), 64'd0);
      chk("rst_ix", 64'({ix_xB, ix_yB, ix_xC, ix_yC, ix_rB, ix_rC}), 64'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("ready_after_rst", 64'(in_ready), 64'd1);

      foreach (tbl[t]) run_job(tbl[t], 1'b1, 1'b0);

      // in_valid held high through a whole job
      run_job(tbl[1], 1'b1, 1'b1);

      // Reset while pair (0,2) is settling
      load3(tbl[0]);
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 100) begin @(negedge clk); lat++; end
      chk("mid_first_valid", 64'(out_valid), 64'd1);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      @(negedge clk);
      chk("mid_settle_pair", 64'({busy, out_valid, ix_xC}), 64'({1'b1, 1'b0, tbl[0].xs[2]}));
      rst = 1'b1;
      #1;
      chk("mid_rst_ctl", 64'({out_valid, busy, out_last, out_degen}), 64'd0);
      chk("mid_rst_out", 64'({out_x1, out_y1, out_x2, out_y2, out_i, out_j}), 64'd0);
      chk("mid_rst_ix", 64'({ix_xB, ix_yB, ix_xC, ix_yC, ix_rB, ix_rC}), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("mid_rst_idle", 64'({in_ready, out_valid, busy}), 64'b100);
      run_job(tbl[2], 1'b1, 1'b0);

      // Random jobs; narrow x range so degenerate pairs occur
      repeat (10) begin
         v = mk(int'($urandom_range(0, 3)), int'($urandom), int'($urandom),
                int'($urandom_range(0, 3)), int'($urandom), int'($urandom),
                int'($urandom_range(0, 3)), int'($urandom), int'($urandom),
                3'b000, int'($urandom_range(0, 3)));
         run_job(v, 1'b0, 1'b0);
      end

      // K=2: one result, last, then DONE and back to LOAD
      r2 = dp_f(8'd4, 8'hFE, 8'hFF, 8'd7, 9'd9, 9'd3);
      @(negedge clk);
      out_ready2 = 1'b1;
      in_valid2 = 1'b1; in_x2 = 8'd4;  in_y2 = 8'hFE; in_r2 = 9'd9;
      @(negedge clk);
      in_x2 = 8'hFF; in_y2 = 8'd7; in_r2 = 9'd3;
      @(negedge clk);
      in_valid2 = 1'b0;
      lat = 1;
      while (!out_valid2 && lat < 100) begin @(negedge clk); lat++; end
      chk("k2_latency", 64'(lat - 1), 64'(SETTLE + 1));
      chk("k2_pair", 64'({out2_i, out2_j, out2_last, out2_degen}), 64'({3'd0, 3'd1, 1'b1, 1'b0}));
      chk("k2_result", 64'({out2_x1, out2_y1, out2_x2, out2_y2}), 64'(r2));
      @(negedge clk);
      chk("k2_done", 64'({busy2, in_ready2, out_valid2}), 64'd0);
      @(negedge clk);
      chk("k2_reload", 64'({in_ready2, busy2, out_valid2}), 64'b100);
      out_ready2 = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
